// File: rtl/sic_sequencer.sv
// Sequences single-bit input changes into a fundamental-mode SIC detector,
// settling DWELL cycles after each change, then reports the sampled detector output.
module sic_sequencer #(
  parameter int DWELL    = 4,
  parameter bit X1_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_x,
  input  logic       cmd_restart,
  output logic       x1,
  output logic       x2,
  output logic       sic_rst_n,
  input  logic       z_in,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_z,
  output logic [1:0] rsp_steps,
  output logic       busy
);

  typedef enum logic [2:0] {RHOLD, IDLE, STEP, SETTLE, RESP} state_t;

  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] target;
  logic [1:0] steps;
  logic       pending;
  logic [1:0] diff;
  logic [1:0] step_mask;

  // When both bits differ only one may move per step; X1_FIRST picks which.
  always_comb begin
    diff      = {x1, x2} ^ target;
    step_mask = diff;
    if (diff == 2'b11)
      step_mask = X1_FIRST ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RHOLD;
      cnt       <= '0;
      target    <= '0;
      steps     <= '0;
      pending   <= 1'b0;
      x1        <= 1'b0;
      x2        <= 1'b0;
      sic_rst_n <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_z     <= 1'b0;
      rsp_steps <= '0;
      busy      <= 1'b1;
    end else begin
      case (state)
        // Counts up from zero; x is 00 here, so target != 00 means a step is needed.
        RHOLD: begin
          if (cnt == DWELL_M1) begin
            sic_rst_n <= 1'b1;
            pending   <= 1'b0;
            cnt       <= DWELL_M1;
            if (!pending) begin
              state     <= IDLE;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
            end else if (target != 2'b00) begin
              state <= STEP;
            end else begin
              state <= SETTLE;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            target    <= cmd_x;
            steps     <= '0;
            pending   <= cmd_restart;
            if (cmd_restart) begin
              x1        <= 1'b0;
              x2        <= 1'b0;
              sic_rst_n <= 1'b0;
              cnt       <= '0;
              state     <= RHOLD;
            end else if (cmd_x != {x1, x2}) begin
              state <= STEP;
            end else begin
              cnt   <= DWELL_M1;
              state <= SETTLE;
            end
          end
        end

        STEP: begin
          {x1, x2} <= {x1, x2} ^ step_mask;
          steps    <= steps + 2'd1;
          cnt      <= DWELL_M1;
          state    <= SETTLE;
        end

        SETTLE: begin
          if (cnt == 8'd0) begin
            if (diff != 2'b00) begin
              state <= STEP;
            end else begin
              rsp_z     <= z_in;
              rsp_steps <= steps;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= RHOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_sic_sequencer.sv
// Bench for sic_sequencer: fixed scenario table, hand-written reset sequences and
// random commands checked cycle by cycle against a transaction-level model.
module tb_sic_sequencer;

  localparam int DWELL    = 4;
  localparam bit X1_FIRST = 1'b1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_x = 2'b00;
  logic       cmd_restart = 1'b0;
  logic       x1, x2, sic_rst_n;
  logic       z_in = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_z;
  logic [1:0] rsp_steps;
  logic       busy;

  int         total = 0;
  int         bad = 0;
  logic [1:0] cur = 2'b00;

  typedef struct {
    logic [1:0] tx;
    bit         rs;
    bit         z;
    int         steps;
    int         lat;
    int         hold;
  } vec_t;

  vec_t vecs[8];

  sic_sequencer #(.DWELL(DWELL), .X1_FIRST(X1_FIRST)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_restart(cmd_restart), .x1(x1), .x2(x2),
    .sic_rst_n(sic_rst_n), .z_in(z_in), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_steps(rsp_steps), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [5:0] obs();
    return {x1, x2, sic_rst_n, rsp_valid, cmd_ready, busy};
  endfunction

  function automatic int nsteps(input logic [1:0] f, input logic [1:0] t);
    return int'(f[0] ^ t[0]) + int'(f[1] ^ t[1]);
  endfunction

  function automatic int latency(input int n, input bit rs);
    return (rs ? DWELL : 0) + ((n == 0) ? DWELL : n * (DWELL + 1));
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resyncDut();
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (DWELL + 2) @(negedge clk);
    cur = 2'b00;
  endtask

  // Issues one command and follows it cycle by cycle through the response handshake.
  task automatic applyStimulus(input logic [1:0] tx, input bit rs, input bit zv,
                               input int exp_steps, input int exp_lat, input int hold);
    int         w;
    int         n;
    int         base;
    int         bad_before;
    logic [1:0] from;
    logic [1:0] mid;
    logic [1:0] expx;
    logic [5:0] e;
    bad_before = bad;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (cmd_ready !== 1'b1) begin
      checkOutput("ready_timeout", 16'(cmd_ready), 16'd1);
      resyncDut();
      return;
    end
    from = rs ? 2'b00 : cur;
    n    = nsteps(from, tx);
    mid  = (n == 2) ? (from ^ (X1_FIRST ? 2'b10 : 2'b01)) : tx;
    base = rs ? DWELL : 0;
    z_in = ~zv;
    cmd_valid = 1'b1;
    cmd_x = tx;
    cmd_restart = rs;
    for (int k = 0; k <= exp_lat; k++) begin
      @(negedge clk);
      expx = from;
      if (n >= 1 && k >= base + 1) expx = mid;
      if (n == 2 && k >= base + DWELL + 2) expx = tx;
      e = {expx, !(rs && k < DWELL), (k == exp_lat), 1'b0, 1'b1};
      checkOutput("trajectory", 16'(obs()), 16'(e));
      cmd_valid   = 1'($urandom_range(0, 1));
      cmd_x       = 2'($urandom_range(0, 3));
      cmd_restart = 1'($urandom_range(0, 1));
      if (k == exp_lat - 1) z_in = zv;
      if (k == exp_lat) z_in = ~zv;
    end
    checkOutput("rsp_z", 16'(rsp_z), 16'(zv));
    checkOutput("rsp_steps", 16'(rsp_steps), 16'(exp_steps));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      cmd_valid = 1'($urandom_range(0, 1));
      z_in = 1'($urandom_range(0, 1));
      checkOutput("hold", 16'({rsp_valid, rsp_z, rsp_steps, cmd_ready, x1, x2}),
                  16'({1'b1, zv, 2'(exp_steps), 1'b0, tx}));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("release", 16'({rsp_valid, cmd_ready, busy, x1, x2}),
                16'({1'b0, 1'b1, 1'b0, tx}));
    cur = tx;
    if (bad != bad_before) resyncDut();
  endtask

  initial begin
    vecs[0] = '{tx: 2'b01, rs: 1'b0, z: 1'b1, steps: 1, lat: 5,  hold: 0};
    vecs[1] = '{tx: 2'b10, rs: 1'b0, z: 1'b0, steps: 2, lat: 10, hold: 6};
    vecs[2] = '{tx: 2'b10, rs: 1'b0, z: 1'b1, steps: 0, lat: 4,  hold: 1};
    vecs[3] = '{tx: 2'b11, rs: 1'b1, z: 1'b0, steps: 2, lat: 14, hold: 0};
    vecs[4] = '{tx: 2'b00, rs: 1'b0, z: 1'b1, steps: 2, lat: 10, hold: 2};
    vecs[5] = '{tx: 2'b00, rs: 1'b1, z: 1'b0, steps: 0, lat: 8,  hold: 0};
    vecs[6] = '{tx: 2'b10, rs: 1'b0, z: 1'b1, steps: 1, lat: 5,  hold: 3};
    vecs[7] = '{tx: 2'b01, rs: 1'b0, z: 1'b0, steps: 2, lat: 10, hold: 0};

    // Power-on reset, then the RHOLD exit DWELL edges after release.
    repeat (2) @(negedge clk);
    checkOutput("reset_vals", 16'({obs(), rsp_z, rsp_steps}), 16'({6'b000001, 1'b0, 2'b00}));
    rst = 1'b0;
    for (int k = 1; k <= DWELL; k++) begin
      @(negedge clk);
      checkOutput("rhold_exit", 16'(obs()),
                  16'({2'b00, (k >= DWELL), 1'b0, (k >= DWELL), (k < DWELL)}));
    end

    for (int i = 0; i < 8; i++)
      applyStimulus(vecs[i].tx, vecs[i].rs, vecs[i].z, vecs[i].steps, vecs[i].lat, vecs[i].hold);

    // Reset while settling must drop everything immediately and abort the command.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_x = cur ^ 2'b01;
    cmd_restart = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_reset", 16'({obs(), rsp_steps}), 16'({6'b000001, 2'b00}));
    @(negedge clk);
    rst = 1'b0;
    repeat (DWELL) @(negedge clk);
    checkOutput("abort", 16'(obs()), 16'(6'b001010));
    cur = 2'b00;

    for (int i = 0; i < 30; i++) begin
      logic [1:0] tx;
      bit         rs;
      int         n;
      tx = 2'($urandom_range(0, 3));
      rs = ($urandom_range(0, 4) == 0);
      n  = nsteps(rs ? 2'b00 : cur, tx);
      applyStimulus(tx, rs, 1'($urandom_range(0, 1)), n, latency(n, rs),
                    int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sic_sequencer.md
SIC_SEQUENCER -- requirements
Module: sic_sequencer

Interface
REQ-001 Parameter DWELL, default 4: settle cycles after each input change; legal range 1..255.
REQ-002 Parameter X1_FIRST, default 1: when both bits must change, 1 = toggle x1 first, 0 = toggle x2 first.
REQ-003 Port clk, input, 1: single clock, rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port cmd_valid, input, 1: command request.
REQ-006 Port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both high on a clock edge.
REQ-007 Port cmd_x, input, 2: target input vector {x1,x2}.
REQ-008 Port cmd_restart, input, 1: drive 00 and reset the detector before moving to the target.
REQ-009 Port x1 and x2, outputs, 1 each: registered drives to the detector inputs.
REQ-010 Port sic_rst_n, output, 1: registered, active-low reset drive to the detector.
REQ-011 Port z_in, input, 1: detector output.
REQ-012 Port rsp_valid, output, 1: response available.
REQ-013 Port rsp_ready, input, 1: response consumed when rsp_valid and rsp_ready are both high on a clock edge.
REQ-014 Port rsp_z, output, 1: sampled z_in.
REQ-015 Port rsp_steps, output, 2: number of single-bit changes applied (0..2).
REQ-016 Port busy, output, 1: high in every state except IDLE.

Function
REQ-017 The FSM SHALL have the states RHOLD, IDLE, STEP, SETTLE and RESP.
REQ-018 RHOLD SHALL hold sic_rst_n=0 and x=00 for DWELL cycles.
- At expiry: sic_rst_n=1.
- Then go to STEP if a latched target differs from 00, to SETTLE if the target is 00, or to IDLE if no command is pending.
REQ-019 IDLE SHALL assert cmd_ready=1; cmd_ready SHALL be 0 in all other states.
REQ-020 On accept, the block SHALL latch cmd_x and cmd_restart and clear the step count.
- If restart: x<=00, sic_rst_n<=0, go to RHOLD.
- Else if target differs from current x: go to STEP.
- Else: go to SETTLE.
REQ-021 STEP SHALL last one cycle and toggle exactly one bit.
- That bit is the only differing bit, or the X1_FIRST choice when both differ.
- The step count increments, the settle counter loads DWELL-1, then go to SETTLE.
REQ-022 SETTLE SHALL count down. At count 0:
- If x differs from the target: go to STEP.
- Else: register z_in into rsp_z and the step count into rsp_steps, then go to RESP.
REQ-023 RESP SHALL hold rsp_valid=1 with rsp_z and rsp_steps stable until rsp_ready=1, then go to IDLE with rsp_valid=0.
REQ-024 Outside RHOLD, x1 and x2 SHALL never change on the same edge, and successive changes SHALL be at least DWELL+1 cycles apart.
REQ-025 The simultaneous 2-bit change to 00 SHALL occur only on the edge that drives sic_rst_n low.
REQ-026 Latency from accept edge to rsp_valid rising (no restart) SHALL be DWELL edges for 0 steps, DWELL+1 edges for 1 step and 2*(DWELL+1) edges for 2 steps.
REQ-027 With restart, the latency SHALL add DWELL edges for RHOLD.
REQ-028 cmd_valid asserted while busy SHALL be ignored: no accept and no state change.
REQ-029 cmd_ready and rsp_valid SHALL never be high in the same cycle.

Reset
REQ-030 While rst=1, outputs SHALL be, immediately and independent of clk: x1=0, x2=0, sic_rst_n=0, cmd_ready=0, rsp_valid=0, rsp_z=0, rsp_steps=0, busy=1, state RHOLD with counter cleared.
REQ-031 Reset mid-operation SHALL abort any in-flight command with no response.
REQ-032 After rst deasserts, the block SHALL complete RHOLD and then enter IDLE.

Verification
REQ-033 Scenario: rst pulse, DWELL=4 -> x=00, sic_rst_n=0, cmd_ready=0; 4 cycles after release sic_rst_n=1 and cmd_ready=1.
REQ-034 Scenario: from 00 accept cmd_x=01 with z_in=1 -> x becomes 01 one edge after accept; rsp_valid 5 edges after accept; rsp_z=1; rsp_steps=1.
REQ-035 Scenario: from 01 accept cmd_x=10 with X1_FIRST=1 -> x sequence 01,11,10 with changes 5 edges apart; never 00; rsp_steps=2; rsp_valid 10 edges after accept.
REQ-036 Scenario: accept cmd_x equal to current x -> x unchanged; rsp_steps=0; rsp_valid 4 edges after accept.
REQ-037 Scenario: from 10 accept cmd_restart=1 with cmd_x=11 -> x=00 and sic_rst_n=0 for 4 cycles, then x sequence 00,10,11; rsp_steps=2.
REQ-038 Scenario: hold rsp_ready=0 for 6 cycles while pulsing cmd_valid -> rsp_valid, rsp_z and rsp_steps stable; no accept. Then assert rst mid-SETTLE -> x=00 and rsp_valid=0 immediately.
